// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: valid/ready front end for a DEPTH-stage shift chain.
// Serial samples in (in_*), filled chain out as a parallel word (out_*).
// Ports: clk, rst_n, in_valid/in_data/in_ready, out_valid/out_data/
// out_ready, flush (clear request), busy (flush running), count (fill).
module shift_chain_ctrl #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DEPTH*WIDTH-1:0]       out_data,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    FLUSH
  } state_t;

  state_t state;
  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic acc;
  logic pop;

  // FULL only takes a sample when the held word leaves in the same edge.
  assign in_ready = !flush &&
    (state == IDLE || state == FILL ||
     (state == FULL && out_ready));
  assign out_valid = (state == FULL) && !flush;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_data = stg;
  assign count = cnt;
  assign busy = (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stg   <= '0;
      cnt   <= '0;
      fcnt  <= '0;
    end else if (flush) begin
      // Also restarts the clear when already flushing.
      state <= FLUSH;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      unique case (state)
        IDLE, FILL: begin
          if (acc) begin
            stg <= {stg[DEPTH-2:0], in_data};
            cnt <= cnt + ONE;
            state <= (cnt + ONE == LAST) ? FULL : FILL;
          end
        end
        FULL: begin
          if (pop) begin
            if (acc) begin
              stg   <= {stg[DEPTH-2:0], in_data};
              cnt   <= ONE;
              state <= FILL;
            end else begin
              // Stages keep stale data; count marks them empty.
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          stg  <= {stg[DEPTH-2:0], ZERO};
          fcnt <= fcnt + ONE;
          if (fcnt == LAST - ONE) begin
            fcnt  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: scenario tasks plus a scoreboard of words.
// DEPTH=3, WIDTH=1; expected words are queued as samples are sent.
module tb_shift_chain_ctrl;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [0:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [2:0] out_data;
  logic out_ready;
  logic flush;
  logic busy;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  logic [2:0] sbq[$];
  logic [2:0] mword;
  int mcnt;

  shift_chain_ctrl #(
    .DEPTH(3),
    .WIDTH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .flush(flush),
    .busy(busy),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 &&
        out_ready === 1'b1) begin
      logic [2:0] exp;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %b req none", out_data);
      end else begin
        exp = sbq.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_word got %b req %b", out_data, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running req finished");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    mword = '0;
    mcnt = 0;
  endtask

  task automatic drive(input logic d);
    in_valid = 1'b1;
    in_data = d;
  endtask

  task automatic commit(input logic d);
    @(posedge clk);
    #1;
    mword = {mword[1:0], d};
    if (mcnt == 3) mcnt = 1;
    else mcnt++;
    if (mcnt == 3) sbq.push_back(mword);
  endtask

  task automatic accept_sample(input logic d);
    drive(d);
    #1;
    commit(d);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0;
    in_data = 0;
    out_ready = 0;
    flush = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b req 0", out_valid);
    end
    if (out_data !== 3'b000) begin
      errors++;
      $display("FAIL rst_out_data got %b req 000", out_data);
    end
    if (count !== 2'd0) begin
      errors++;
      $display("FAIL rst_count got %0d req 0", count);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b req 0", busy);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b req 1", in_ready);
    end
    rst_n = 1'b1;
    accept_sample(1);
    accept_sample(1);
    accept_sample(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out_valid got %b req 0", out_valid);
    end
    if (out_data !== 3'b000) begin
      errors++;
      $display("FAIL midrst_out_data got %b req 000", out_data);
    end
    if (count !== 2'd0) begin
      errors++;
      $display("FAIL midrst_count got %0d req 0", count);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy got %b req 0", busy);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready got %b req 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [1:0] exp_c;
    exp_c = 2'd1;
    foreach (exp_c[i]) begin end
    accept_sample(1);
    checks++;
    if (count !== 2'd1) begin
      errors++;
      $display("FAIL fill_count1 got %0d req 1", count);
    end
    accept_sample(0);
    checks++;
    if (count !== 2'd2) begin
      errors++;
      $display("FAIL fill_count2 got %0d req 2", count);
    end
    accept_sample(1);
    checks += 4;
    if (count !== 2'd3) begin
      errors++;
      $display("FAIL fill_count3 got %0d req 3", count);
    end
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_valid got %b req 1", out_valid);
    end
    if (out_data !== 3'b101) begin
      errors++;
      $display("FAIL fill_data got %b req 101", out_data);
    end
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_in_ready got %b req 0", in_ready);
    end
    drive(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, count, out_data} !== 6'b1_11_101) begin
        errors++;
        $display("FAIL fill_hold%0d got %b%0d%b req 1/3/101",
                 i, out_valid, count, out_data);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pop_accept();
    out_ready = 1'b1;
    drive(0);
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pa_in_ready got %b req 1", in_ready);
    end
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pa_out_valid got %b req 1", out_valid);
    end
    commit(0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks += 5;
    if (count !== 2'd1) begin
      errors++;
      $display("FAIL pa_count got %0d req 1", count);
    end
    if (out_data !== 3'b010) begin
      errors++;
      $display("FAIL pa_data got %b req 010", out_data);
    end
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pa_valid got %b req 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pa_fill_ready got %b req 1", in_ready);
    end
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pa_popped got %0d left req 0", sbq.size());
    end
  endtask

  task automatic test_bubbles();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_clear();
    accept_sample(1);
    in_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({count, out_data} !== 5'b01_001) begin
        errors++;
        $display("FAIL bub_gap%0d got %0d/%b req 1/001",
                 i, count, out_data);
      end
      @(posedge clk);
      #1;
    end
    accept_sample(1);
    checks += 2;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bub_early_valid got %b req 0", out_valid);
    end
    if (count !== 2'd2) begin
      errors++;
      $display("FAIL bub_count2 got %0d req 2", count);
    end
    accept_sample(0);
    checks += 2;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bub_valid got %b req 1", out_valid);
    end
    if (out_data !== 3'b110) begin
      errors++;
      $display("FAIL bub_data got %b req 110", out_data);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mcnt = 0;
    checks += 2;
    if ({out_valid, count} !== 3'b0_00) begin
      errors++;
      $display("FAIL bub_idle got %b/%0d req 0/0", out_valid, count);
    end
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL bub_popped got %0d left req 0", sbq.size());
    end
  endtask

  task automatic test_flush();
    accept_sample(1);
    accept_sample(1);
    flush = 1'b1;
    drive(1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fl_in_ready got %b req 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy, in_ready, count} !== 4'b1_0_00) begin
        errors++;
        $display("FAIL fl_busy%0d got %b/%b/%0d req 1/0/0",
                 i, busy, in_ready, count);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({busy, in_ready, count, out_data} !== 7'b0_1_00_000) begin
      errors++;
      $display("FAIL fl_done got %b/%b/%0d/%b req 0/1/0/000",
               busy, in_ready, count, out_data);
    end
    in_valid = 1'b0;
    model_clear();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) flush = 1'b1;
      #1;
      checks++;
      if (busy !== (c <= 5) || in_ready !== (c == 6)) begin
        errors++;
        $display("FAIL fl_ext%0d got %b/%b req %b/%b",
                 c, busy, in_ready, c <= 5, c == 6);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic test_flush_pop();
    accept_sample(1);
    accept_sample(0);
    accept_sample(0);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fp_valid got %b req 0", out_valid);
    end
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_in_ready got %b req 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    checks += 2;
    if ({busy, count} !== 3'b1_00) begin
      errors++;
      $display("FAIL fp_flush got %b/%0d req 1/0", busy, count);
    end
    if (sbq.size() != 1) begin
      errors++;
      $display("FAIL fp_no_pop got %0d left req 1", sbq.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, out_data} !== 4'b0_000) begin
      errors++;
      $display("FAIL fp_done got %b/%b req 0/000", busy, out_data);
    end
    sbq.delete();
    model_clear();
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq;
    seq = 6'b110010;
    out_ready = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      drive(seq[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b req 1", 5 - i, in_ready);
      end
      commit(seq[i]);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mcnt = 0;
    checks += 2;
    if ({out_valid, count} !== 3'b0_00) begin
      errors++;
      $display("FAIL b2b_idle got %b/%0d req 0/0", out_valid, count);
    end
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d left req 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_accept();
    test_bubbles();
    test_flush();
    test_flush_pop();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_chain_ctrl.md
# shift_chain_ctrl

Controller that sequences a parameterised non-blocking shift chain. It accepts one WIDTH-bit sample per handshake, shifts it through DEPTH stages and presents the filled chain as a parallel word on a valid/ready output. A flush operation clears the chain by shifting in zeros. It sits between a serial producer and a word-wide consumer as the managed front end of the delay-line datapath.

## Interface
Parameters:
- DEPTH, 3: number of shift stages; must be ≥ 2.
- WIDTH, 1: bits per stage.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a sample.
- in_data  in  WIDTH  sample.
- in_ready  out  1  controller accepts the sample this cycle.
- out_valid  out  1  parallel word available.
- out_data  out  DEPTH*WIDTH  {stage[DEPTH-1], …, stage[0]}; the oldest sample is in the MSBs.
- out_ready  in  1  consumer takes the word.
- flush  in  1  request a chain clear; sampled every cycle.
- busy  out  1  high while a flush is in progress.
- count  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Storage: stage[0..DEPTH-1], each WIDTH bits. A shift does stage[0] <= new value and stage[i] <= stage[i-1]. All stages update together from their pre-edge values.
- Accept: when in_valid && in_ready, shift in in_data.
- Pop: when out_valid && out_ready, the word is consumed.
- States:
  - IDLE: count = 0.
  - FILL: 0 < count < DEPTH.
  - FULL: count = DEPTH.
  - FLUSH: chain clear in progress.
- Transitions:
  - IDLE or FILL, on accept: count+1. Go to FULL when the count reaches DEPTH, otherwise stay in or enter FILL.
  - FULL, pop without accept: go to IDLE with count = 0. Stage contents are retained but stale.
  - FULL, pop with accept in the same cycle: shift, go to FILL with count = 1.
  - FULL, no pop: hold. The chain does not shift.
  - FLUSH: shift zero once per cycle for DEPTH cycles (internal counter), then go to IDLE with count = 0 and all stages zero.
- Flush priority:
  - flush = 1 in any state enters FLUSH next cycle and sets count = 0.
  - Any concurrent accept or pop is ignored; in_ready and out_valid are already forced low by the flush.
  - flush = 1 while in FLUSH restarts the DEPTH-cycle counter.
- Derived outputs:
  - in_ready = !flush && (state==IDLE || state==FILL || (state==FULL && out_ready)).
  - out_valid = (state==FULL) && !flush.
  - busy = (state==FLUSH).
- No accept while in FLUSH. A bubble (in_valid = 0) never shifts the chain.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, all stages 0, count 0, flush counter 0.
  - Outputs during and after reset: out_valid 0, out_data 0, busy 0, in_ready 1 when flush = 0.
- Fill latency: out_valid rises in the cycle after the DEPTH-th accept. With back-to-back input this is DEPTH cycles after the first accept edge.
- Throughput: one word per DEPTH cycles, sustained via same-cycle pop+accept in FULL. There is no dead cycle.
- in_ready and out_valid have combinational paths from out_ready and flush. There is no path from in_valid to in_ready.
- Flush duration: busy is high for exactly DEPTH cycles starting the cycle after flush is sampled. in_ready returns to 1 on the first IDLE cycle.
- Reset asserted mid-operation: all state clears immediately and any partial fill is discarded. The first edge after rst_n rises behaves as IDLE.
- out_data and count are registered values; they change only on clock edges or reset.

## Test plan
- Reset: drive rst_n low mid-cycle with chain full. Required: out_valid, out_data, count, busy all 0 immediately, before the next edge; in_ready 1.
- Fill, DEPTH=3 WIDTH=1: accept 1,0,1 back to back with out_ready=0. Required: count 1,2,3; out_valid 1 and out_data 3'b101 on the cycle after the third accept; in_ready 0; values held for 5 cycles.
- Simultaneous pop+accept: from FULL with 3'b101, set out_ready=1 and in_valid=1 with in_data=0. Required: word 3'b101 consumed; next cycle count 1, stage[0]=0, out_valid 0, state FILL.
- Bubbles: accept 1, then in_valid=0 for 4 cycles, then accept 1 and 0. Required: no shift during the gap; out_data 3'b110; out_valid only after the third accept.
- Flush mid-fill: after accepting 1,1, pulse flush with in_valid=1. Required: that sample is rejected; busy high for 3 cycles; in_ready 0 throughout; then stages all 0, count 0, state IDLE. A second flush pulse in busy cycle 2 extends busy to cycle 5.
- Flush versus pop: in FULL, assert flush and out_ready together. Required: out_valid 0 that cycle, no word consumed, FLUSH entered.
